// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and framing constants for the SPI target.
package spi_pkg;
  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} spi_target_state_t;
  localparam int CMD_OP_BIT = 7;
  localparam int CMD_ADDR_W = 7;
  localparam int SPI_BITS = 8;
endpackage

// File: rtl/spi_target_if.sv
// spi_target_if: SPI pins, local buffer port and status of the SPI target.
interface spi_target_if #(parameter int MEMORY_SIZE_IN_BYTES = 10);
  localparam int ADDR_W = $clog2(MEMORY_SIZE_IN_BYTES);
  logic sclk, mosi, cs_n, miso, miso_oe;
  logic [7:0] data_in, data_out;
  logic wr, busy, done;
  logic [ADDR_W-1:0] address;
  modport master (output sclk, mosi, cs_n, data_in,
                  input miso, miso_oe, data_out, wr, address, busy, done);
  modport slave (input sclk, mosi, cs_n, data_in,
                 output miso, miso_oe, data_out, wr, address, busy, done);
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-FF synchronizer with single-clk rise/fall pulses.
module spi_sync_edge #(parameter logic RST_VAL = 1'b0) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [2:0] sr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr <= {3{RST_VAL}};
    else sr <= {sr[1:0], din};
  assign level = sr[1];
  assign rise = sr[1] & ~sr[2];
  assign fall = ~sr[1] & sr[2];
endmodule

// File: rtl/spi_target.sv
// spi_target: SPI mode-0 responder bridging a command/data byte stream to a local buffer.
module spi_target
  import spi_pkg::*;
#(parameter int MEMORY_SIZE_IN_BYTES = 10) (
  input logic clk,
  input logic rst_n,
  spi_target_if.slave bus
);
  localparam int ADDR_W = $clog2(MEMORY_SIZE_IN_BYTES);
  spi_target_state_t state, state_nx;
  logic sclk_s, sclk_rise, sclk_fall, mosi_s, mosi_rise, mosi_fall;
  logic cs_n_s, cs_rise, cs_fall, unused;
  logic [2:0] bit_cnt;
  logic [SPI_BITS-1:0] rx_shift, tx_shift, rx_byte, data_out;
  logic [ADDR_W-1:0] addr, addr_inc, cmd_addr;
  logic miso, wr, done, reload, byte_done;
  spi_sync_edge u_sclk (.clk(clk), .rst_n(rst_n), .din(bus.sclk),
                        .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge u_mosi (.clk(clk), .rst_n(rst_n), .din(bus.mosi),
                        .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall));
  // cs_n idles high, so its synchronizer resets high to avoid a false select edge
  spi_sync_edge #(.RST_VAL(1'b1)) u_cs (.clk(clk), .rst_n(rst_n), .din(bus.cs_n),
                                        .level(cs_n_s), .rise(cs_rise), .fall(cs_fall));
  assign unused = ^{sclk_s, mosi_rise, mosi_fall, cs_n_s};
  assign rx_byte = {rx_shift[SPI_BITS-2:0], mosi_s};
  assign byte_done = sclk_rise && bit_cnt == 3'd7 && state != IDLE && !cs_rise;
  assign addr_inc = (addr == ADDR_W'(MEMORY_SIZE_IN_BYTES - 1)) ? '0 : addr + ADDR_W'(1);
  assign cmd_addr = ({1'b0, rx_byte[CMD_ADDR_W-1:0]} >= 8'(MEMORY_SIZE_IN_BYTES)) ? '0
                    : ADDR_W'(rx_byte[CMD_ADDR_W-1:0]);
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = cs_fall ? CMD : IDLE;
    else if (cs_rise) state_nx = IDLE;
    else if (byte_done && state == CMD) state_nx = rx_byte[CMD_OP_BIT] ? WRITE : READ;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bit_cnt <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      miso <= 1'b0;
      addr <= '0;
      data_out <= '0;
      wr <= 1'b0;
      done <= 1'b0;
      reload <= 1'b0;
    end else begin
      state <= state_nx;
      wr <= byte_done && state == WRITE;
      done <= cs_rise && state != IDLE;
      if (cs_fall) bit_cnt <= '0;
      else if (sclk_rise && state != IDLE) bit_cnt <= bit_cnt + 3'd1;
      if (sclk_rise && state != IDLE) rx_shift <= rx_byte;
      if (byte_done && state == WRITE) data_out <= rx_byte;
      // writes advance the address after the strobe; reads advance at byte end
      if (byte_done && state == CMD) addr <= cmd_addr;
      else if (wr || (byte_done && state == READ)) addr <= addr_inc;
      reload <= (byte_done && state_nx == READ) || (reload && !sclk_fall && state != IDLE);
      if (state != READ || cs_rise) miso <= 1'b0;
      else if (sclk_fall) begin
        miso <= reload ? bus.data_in[SPI_BITS-1] : tx_shift[SPI_BITS-2];
        tx_shift <= reload ? bus.data_in : {tx_shift[SPI_BITS-2:0], 1'b0};
      end
    end
  assign bus.miso = miso;
  assign bus.miso_oe = state != IDLE;
  assign bus.busy = state != IDLE;
  assign bus.data_out = data_out;
  assign bus.wr = wr;
  assign bus.address = addr;
  assign bus.done = done;
endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: directed vector table plus randomized transactions against a buffer model.
module tb_spi_target;
  localparam int MEM = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  spi_target_if #(.MEMORY_SIZE_IN_BYTES(MEM)) bus();
  spi_target #(.MEMORY_SIZE_IN_BYTES(MEM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [7:0] mem [MEM];
  logic [7:0] ref_mem [MEM];
  assign bus.data_in = (int'(bus.address) < MEM) ? mem[bus.address] : 8'h00;
  int checks = 0;
  int failures = 0;
  int done_total = 0;
  logic [3:0] wr_a_q [$];
  logic [7:0] wr_d_q [$];
  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];
  always @(negedge clk) begin
    if (bus.wr) begin
      wr_a_q.push_back(bus.address);
      wr_d_q.push_back(bus.data_out);
      if (int'(bus.address) < MEM) mem[bus.address] = bus.data_out;
    end
    if (bus.done) done_total++;
  end
  typedef struct {
    logic [7:0] cmd;
    int n;
    int extra;
    logic [0:3][7:0] d;
    logic [0:3][3:0] ea;
    logic [0:3][7:0] er;
  } vec_t;
  vec_t vecs [6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic int maddr(input logic [7:0] cmd, input int i);
    int a;
    a = (int'(cmd[6:0]) >= MEM) ? 0 : int'(cmd[6:0]);
    return (a + i) % MEM;
  endfunction
  task automatic send_bits(input logic [7:0] v, input int nb, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < nb; i++) begin
      bus.mosi = v[7-i];
      tick(4);
      r = {r[6:0], bus.miso};
      bus.sclk = 1'b1;
      tick(4);
      bus.sclk = 1'b0;
    end
  endtask
  task automatic apply(input logic [7:0] cmd, input int n, input int extra, input logic [0:3][7:0] d,
                       input logic [0:3][3:0] ea, input logic [0:3][7:0] er);
    int base, dbase;
    logic [7:0] r;
    base = wr_a_q.size();
    dbase = done_total;
    tx_q = {cmd};
    for (int i = 0; i < n; i++) tx_q.push_back(d[i]);
    rx_q = {};
    bus.cs_n = 1'b0;
    tick(4);
    chk("busy_active", bus.busy, 1);
    chk("oe_active", bus.miso_oe, 1);
    foreach (tx_q[k]) begin
      send_bits(tx_q[k], 8, r);
      rx_q.push_back(r);
    end
    if (extra > 0) send_bits(8'($urandom), extra, r);
    bus.cs_n = 1'b1;
    tick(8);
    chk("done_pulses", done_total - dbase, 1);
    chk("busy_idle", bus.busy, 0);
    chk("oe_idle", bus.miso_oe, 0);
    chk("miso_idle", bus.miso, 0);
    if (cmd[7]) begin
      chk("wr_count", wr_a_q.size() - base, n);
      for (int i = 0; i < n; i++)
        if (base + i < wr_a_q.size()) begin
          chk("wr_addr", wr_a_q[base+i], ea[i]);
          chk("wr_data", wr_d_q[base+i], d[i]);
        end
      for (int i = 0; i < n; i++) ref_mem[maddr(cmd, i)] = d[i];
    end else begin
      chk("rd_cmd_miso", rx_q[0], 0);
      chk("rd_no_wr", wr_a_q.size() - base, 0);
      for (int i = 0; i < n; i++) chk("rd_data", rx_q[i+1], er[i]);
    end
  endtask
  initial begin
    #800000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] cmd, r;
    logic [0:3][7:0] d, er;
    logic [0:3][3:0] ea;
    int n, extra, base, dbase;
    vecs[0] = '{8'h82, 3, 0, {8'hA5, 8'h3C, 8'h7E, 8'h00}, {4'd2, 4'd3, 4'd4, 4'd0}, 32'h0};
    vecs[1] = '{8'h05, 3, 0, {8'hFF, 8'h00, 8'hAA, 8'h00}, 16'h0, {8'h05, 8'h06, 8'h07, 8'h00}};
    vecs[2] = '{8'h09, 2, 0, {8'h55, 8'hC3, 8'h00, 8'h00}, 16'h0, {8'h09, 8'h00, 8'h00, 8'h00}};
    vecs[3] = '{8'h88, 3, 0, {8'h11, 8'h22, 8'h33, 8'h00}, {4'd8, 4'd9, 4'd0, 4'd0}, 32'h0};
    vecs[4] = '{8'h8F, 1, 5, {8'h5A, 8'h00, 8'h00, 8'h00}, {4'd0, 4'd0, 4'd0, 4'd0}, 32'h0};
    vecs[5] = '{8'h08, 3, 0, {8'h00, 8'hFF, 8'h0F, 8'h00}, 16'h0, {8'h11, 8'h22, 8'h5A, 8'h00}};
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.cs_n = 1'b1;
    for (int i = 0; i < MEM; i++) begin
      mem[i] = 8'(i);
      ref_mem[i] = 8'(i);
    end
    tick(3);
    chk("rst_miso", bus.miso, 0);
    chk("rst_oe", bus.miso_oe, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_wr", bus.wr, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_addr", bus.address, 0);
    chk("rst_dout", bus.data_out, 0);
    rst_n = 1'b1;
    tick(4);
    base = wr_a_q.size();
    dbase = done_total;
    repeat (16) begin
      bus.mosi = 1'($urandom);
      bus.sclk = 1'b1;
      tick(3);
      bus.sclk = 1'b0;
      tick(3);
    end
    tick(4);
    chk("noise_wr", wr_a_q.size() - base, 0);
    chk("noise_done", done_total - dbase, 0);
    chk("noise_oe", bus.miso_oe, 0);
    chk("noise_busy", bus.busy, 0);
    for (int v = 0; v < 6; v++)
      apply(vecs[v].cmd, vecs[v].n, vecs[v].extra, vecs[v].d, vecs[v].ea, vecs[v].er);
    // asynchronous reset in the middle of bit 3 of a read data byte
    base = wr_a_q.size();
    dbase = done_total;
    bus.cs_n = 1'b0;
    tick(4);
    send_bits(8'h03, 8, r);
    send_bits(8'h00, 2, r);
    bus.mosi = 1'b1;
    tick(4);
    bus.sclk = 1'b1;
    tick(2);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_miso", bus.miso, 0);
    chk("mid_rst_oe", bus.miso_oe, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_addr", bus.address, 0);
    chk("mid_rst_dout", bus.data_out, 0);
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    tick(4);
    rst_n = 1'b1;
    tick(4);
    chk("mid_rst_no_wr", wr_a_q.size() - base, 0);
    chk("mid_rst_no_done", done_total - dbase, 0);
    apply(8'h01, 1, 0, 32'h00000000, 16'h0, {8'h01, 8'h00, 8'h00, 8'h00});
    repeat (20) begin
      cmd = {1'($urandom), 7'($urandom_range(0, 15))};
      n = $urandom_range(1, 4);
      extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      d = $urandom;
      for (int i = 0; i < 4; i++) begin
        ea[i] = 4'(maddr(cmd, i));
        er[i] = ref_mem[maddr(cmd, i)];
      end
      apply(cmd, n, extra, d, ea, er);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI mode-0 responder (slave) that sits at the far end of the link from spi_controller.
- Exposes a byte-wide memory port to a local buffer: bytes received on mosi are written to it, and bytes read from it are shifted out on miso.
- sclk, mosi and cs_n are oversampled in the system clk domain, so no second clock exists.
- Framing: one command byte per cs_n-low transaction, followed by any number of data bytes at auto-incrementing addresses.

Parameters:
- MEMORY_SIZE_IN_BYTES, 10, depth of local buffer. Legal range 2..128.
- ADDR_W, $clog2(MEMORY_SIZE_IN_BYTES), address width (derived; do not override).

Ports:
- clk  input  1  system clock; must run ≥4x sclk.
- rst_n  input  1  asynchronous active-low reset.
- sclk  input  1  SPI clock from controller, idle low.
- mosi  input  1  serial data in, MSB first.
- cs_n  input  1  active-low select; frames a transaction.
- miso  output  1  serial data out, MSB first.
- miso_oe  output  1  high while selected; pad tri-state enable.
- data_in  input  8  read data, mem[address], combinational.
- data_out  output  8  write data.
- wr  output  1  one-clk write strobe.
- address  output  ADDR_W  buffer address.
- busy  output  1  high from cs_n fall until return to IDLE.
- done  output  1  one-clk pulse at end of transaction.

Behaviour:
- Reset values: all outputs 0; state IDLE; shift registers and bit counter 0.
- Input conditioning:
  - sclk, mosi and cs_n each pass through a 2-FF synchronizer.
  - rise, fall, cs_fall and cs_rise are single-clk pulses derived from the synchronized sclk and cs_n.
  - Sample latency is 2 clk after a pin edge.
- Sampling: mosi is sampled into rx_shift on each rise; miso changes only on fall (mode 0, CPOL=0, CPHA=0).
- Bit counter: 3 bits, cleared on cs_fall, incremented on each rise. A byte completes on the rise where the counter wraps 7→0.
- States: IDLE, CMD, WRITE, READ.
- IDLE:
  - miso=0, miso_oe=0, busy=0.
  - cs_fall → CMD; busy=1, miso_oe=1, miso=0.
- CMD (byte completes, cmd = received byte):
  - address ← cmd[6:0]. If cmd[6:0] ≥ MEMORY_SIZE_IN_BYTES, address ← 0.
  - cmd[7]=1 → WRITE.
  - cmd[7]=0 → READ. On the next fall, tx_shift ← data_in and miso ← data_in[7].
- WRITE (byte completes):
  - Next clk: data_out ← byte, wr=1 for exactly 1 clk.
  - The clk after that: address increments.
  - miso is held 0 in this state.
- READ:
  - On each fall, shift tx_shift left and drive the new MSB on miso.
  - On the fall following a byte-complete rise: address has already incremented at byte-complete; reload tx_shift ← data_in and miso ← data_in[7].
  - data_in is therefore sampled ≥1 clk after the address change.
- Address wrap: MEMORY_SIZE_IN_BYTES-1 → 0, in both WRITE and READ.
- cs_rise in any non-IDLE state:
  - Partial byte discarded; no wr issued for it.
  - → IDLE; done=1 for 1 clk; miso_oe=0, miso=0.
- cs_fall while non-IDLE: cannot occur without an intervening cs_rise. cs_rise has priority if both are detected in the same clk.
- Edge coincidence: rise and fall are never both set in one clk, given the ≥4x oversampling constraint.
- A wr issued on the final byte completes before done.
- rst_n low mid-transaction: immediate return to reset values; no wr or done pulse.
- sclk edges while in IDLE (cs_n high) are ignored.

Decomposition:
- spi_pkg holds:
  - typedef enum logic [1:0] spi_target_state_t {IDLE, CMD, WRITE, READ}.
  - localparam CMD_OP_BIT = 7.
  - localparam CMD_ADDR_W = 7.
  - localparam SPI_BITS = 8.
- Sub-module spi_sync_edge: 2-FF synchronizer plus rise/fall pulse generator for a single bit. Instantiated three times (sclk, mosi, cs_n; mosi uses only the level).

Test Plan:
- Write burst: cs_n low, send 0x82, 0xA5, 0x3C, 0x7E → wr pulses with (address,data_out) = (2,0xA5), (3,0x3C), (4,0x7E); then cs_n high → done pulse, miso_oe=0.
- Read burst: buffer preloaded 0..9; send 0x05 then 3 dummy bytes → miso bytes 0x05, 0x06, 0x07, each MSB valid before the first rise of its byte.
- Wrap: write cmd 0x88 + 3 bytes (MEM=10) → writes to addresses 8, 9, 0. Read cmd 0x09 + 2 bytes → miso 0x09, 0x00.
- Out-of-range and abort: cmd 0x8F (addr 15) → first write lands at address 0. Then raise cs_n after 5 bits of the next byte → no wr, done=1, state IDLE.
- Reset mid-read: assert rst_n low during bit 3 of a read byte → all outputs 0 immediately. Release, new read 0x01 → miso byte 0x01 correct.
- Noise in idle: toggle sclk/mosi 16 times with cs_n high → no wr, no done, miso_oe=0, busy=0.
